// File: rtl/dram_arb_pkg.sv
// Shared constants and types for the DRAM port arbiter.
package dram_arb_pkg;

    // Arbitration modes selectable through ARB_MODE.
    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // Control half of the command slot; the payload fields are sized by the
    // instantiating module's parameters and live beside it.
    typedef struct packed {
        logic valid;
        logic is_read;
    } cmd_slot_ctrl_t;

endpackage

// File: rtl/dram_tag_fifo.sv
// In-order tag FIFO: remembers which port issued each outstanding read.
module dram_tag_fifo
    import dram_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// N-port arbiter onto the single DRAM wrapper command channel with in-order
// read-data routing back to the issuing port.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned ADDR_WIDTH      = 27,
    parameter int unsigned DATA_WIDTH      = 128,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ARB_MODE        = 0
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic [NUM_PORTS-1:0]                req_ren,
    input  logic [NUM_PORTS-1:0]                req_wen,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_wmask,
    output logic [NUM_PORTS-1:0]                req_ready,
    output logic [DATA_WIDTH-1:0]               resp_rdata,
    output logic [NUM_PORTS-1:0]                resp_valid,
    output logic                                dram_ren,
    output logic                                dram_wen,
    output logic [ADDR_WIDTH-1:0]               dram_addr,
    output logic [DATA_WIDTH-1:0]               dram_wdata,
    output logic [(DATA_WIDTH/8)-1:0]           dram_wmask,
    input  logic                                dram_busy,
    input  logic                                dram_init_calib_complete,
    input  logic [DATA_WIDTH-1:0]               dram_rdata,
    input  logic                                dram_rdata_valid,
    output logic                                err_orphan
);

    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W      = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W      = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0]     MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [NUM_PORTS-1:0] PORT0   = NUM_PORTS'(1);

    cmd_slot_ctrl_t          slot;
    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_PORTS];
    logic [MASK_WIDTH-1:0]   wmask_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0]    eligible;
    logic [IDX_W-1:0]        rr_next;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        cand;
    logic [IDX_W-1:0]        tag_head;
    logic [CNT_W-1:0]        outstanding;
    int unsigned             rr_idx;
    logic                    grant_any;
    logic                    grant_read;
    logic                    can_load;
    logic                    slot_drain;
    logic                    tag_push;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    ret_hit;

    assign slot_drain = slot.valid & ~dram_busy;
    assign can_load   = dram_init_calib_complete & (~slot.valid | ~dram_busy);
    assign dram_ren   = slot.valid & slot.is_read;
    assign dram_wen   = slot.valid & ~slot.is_read;
    assign grant_read = ~req_wen[grant_idx];
    assign tag_push   = grant_any & grant_read;
    assign ret_hit    = dram_rdata_valid & ~fifo_empty;
    assign req_ready  = grant_any ? (PORT0 << grant_idx) : '0;

    // Unpack per-port fields and decide which ports may be granted.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            wmask_arr[i] = req_wmask[i*MASK_WIDTH +: MASK_WIDTH];
            eligible[i]  = req_wen[i] | (req_ren[i] & (outstanding < MAX_CNT));
        end
    end

    // Priority select; loops run from lowest to highest priority so the last
    // hit wins, which avoids an early exit.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        cand      = '0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int unsigned i = NUM_PORTS; i > 0; i--) begin
                cand = IDX_W'(i - 1);
                if (eligible[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end else begin
            for (int unsigned k = NUM_PORTS; k > 0; k--) begin
                rr_idx = 32'(rr_next) + k - 1;
                if (rr_idx >= NUM_PORTS) rr_idx = rr_idx - NUM_PORTS;
                cand = IDX_W'(rr_idx);
                if (eligible[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        grant_any = grant_any & can_load;
    end

    // Round-robin pointer: next search starts just after the granted port.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_next <= '0;
        end else if (grant_any) begin
            rr_next <= (32'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Command slot: loads on grant (possibly while draining), holds while busy.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            slot       <= '0;
            dram_addr  <= '0;
            dram_wdata <= '0;
            dram_wmask <= '0;
        end else if (grant_any) begin
            slot.valid   <= 1'b1;
            slot.is_read <= grant_read;
            dram_addr    <= addr_arr[grant_idx];
            dram_wdata   <= wdata_arr[grant_idx];
            dram_wmask   <= wmask_arr[grant_idx];
        end else if (slot_drain) begin
            slot.valid <= 1'b0;
        end
    end

    dram_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (tag_push),
        .push_data (grant_idx),
        .pop       (dram_rdata_valid),
        .pop_data  (tag_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding)
    );

    // Read eligibility is limited by the count, so a full FIFO never sees a push.
    a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
        !(tag_push & fifo_full & ~dram_rdata_valid));

    // Return path: route data to the head tag; flag data with no owner.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            resp_valid <= '0;
            resp_rdata <= '0;
            err_orphan <= 1'b0;
        end else begin
            resp_valid <= ret_hit ? (PORT0 << tag_head) : '0;
            if (ret_hit) resp_rdata <= dram_rdata;
            if (dram_rdata_valid & fifo_empty) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench: table-driven cycles plus scoreboards for the command
// channel and the read-return routing.
module tb_dram_port_arbiter;

    localparam int unsigned AW = 27;
    localparam int unsigned DW = 128;
    localparam int unsigned MW = 16;
    localparam logic [DW-1:0] WD0 = {16{8'h55}};
    localparam logic [DW-1:0] WD1 = {16{8'h3C}};
    localparam logic [MW-1:0] WM0 = 16'hFFFF;
    localparam logic [MW-1:0] WM1 = 16'h00F0;

    logic          clock = 1'b0;
    logic          resetn;
    logic [1:0]    req_ren, req_wen;
    logic [AW-1:0] a0, a1;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*MW-1:0] req_wmask;
    logic          dram_busy, calib, dram_rdata_valid;
    logic [DW-1:0] dram_rdata;

    logic [1:0]    req_ready, resp_valid;
    logic [DW-1:0] resp_rdata, dram_wdata;
    logic          dram_ren, dram_wen, err_orphan;
    logic [AW-1:0] dram_addr;
    logic [MW-1:0] dram_wmask;

    logic [1:0]    rdy_b, rv_b;
    logic [DW-1:0] rd_b, wd_b;
    logic          ren_b, wen_b, orph_b;
    logic [AW-1:0] addr_b;
    logic [MW-1:0] wm_b;

    assign req_addr  = {a1, a0};
    assign req_wdata = {WD1, WD0};
    assign req_wmask = {WM1, WM0};

    always #5 clock = ~clock;

    dram_port_arbiter #(
        .NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MAX_OUTSTANDING(4), .ARB_MODE(0)
    ) dut (
        .clock(clock), .resetn(resetn), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .req_ready(req_ready), .resp_rdata(resp_rdata), .resp_valid(resp_valid),
        .dram_ren(dram_ren), .dram_wen(dram_wen), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_wmask(dram_wmask), .dram_busy(dram_busy),
        .dram_init_calib_complete(calib), .dram_rdata(dram_rdata),
        .dram_rdata_valid(dram_rdata_valid), .err_orphan(err_orphan)
    );

    dram_port_arbiter #(
        .NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MAX_OUTSTANDING(4), .ARB_MODE(1)
    ) dut_fixed (
        .clock(clock), .resetn(resetn), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .req_ready(rdy_b), .resp_rdata(rd_b), .resp_valid(rv_b),
        .dram_ren(ren_b), .dram_wen(wen_b), .dram_addr(addr_b),
        .dram_wdata(wd_b), .dram_wmask(wm_b), .dram_busy(dram_busy),
        .dram_init_calib_complete(calib), .dram_rdata(dram_rdata),
        .dram_rdata_valid(dram_rdata_valid), .err_orphan(orph_b)
    );

    typedef struct {
        logic [1:0]    ren, wen;
        logic [AW-1:0] a0, a1;
        logic          busy, calib, rvld;
        logic [7:0]    rbyte;
        logic [1:0]    exp_ready;
    } vec_t;

    typedef struct {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } cmd_t;

    typedef struct {
        logic [1:0]    vld;
        logic [DW-1:0] data;
    } resp_t;

    vec_t  vq[$];
    cmd_t  cmd_q[$];
    int    tag_q[$];
    resp_t resp_q[$];
    logic  exp_orphan = 1'b0;
    int    checks = 0;
    int    errors = 0;

    function automatic vec_t mk(logic [1:0] ren, logic [1:0] wen, logic [AW-1:0] x0,
                                logic [AW-1:0] x1, logic busy, logic cal, logic rvld,
                                logic [7:0] rbyte, logic [1:0] exp_ready);
        vec_t v;
        v.ren = ren; v.wen = wen; v.a0 = x0; v.a1 = x1; v.busy = busy;
        v.calib = cal; v.rvld = rvld; v.rbyte = rbyte; v.exp_ready = exp_ready;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        req_ren = v.ren; req_wen = v.wen; a0 = v.a0; a1 = v.a1;
        dram_busy = v.busy; calib = v.calib; dram_rdata_valid = v.rvld;
        dram_rdata = {16{v.rbyte}};
    endtask

    // Per-cycle scoreboard, evaluated on the falling edge.
    task automatic monitor(input logic [1:0] exp_ready);
        cmd_t  c;
        resp_t r;
        int    p;
        chk("req_ready", DW'(req_ready), DW'(exp_ready));
        if (cmd_q.size() > 0) begin
            c = cmd_q[0];
            chk("cmd_ren", DW'(dram_ren), DW'(c.rd));
            chk("cmd_wen", DW'(dram_wen), DW'(!c.rd));
            chk("cmd_addr", DW'(dram_addr), DW'(c.addr));
            if (!c.rd) begin
                chk("cmd_wdata", dram_wdata, c.wdata);
                chk("cmd_wmask", DW'(dram_wmask), DW'(c.wmask));
            end
            if (!dram_busy) void'(cmd_q.pop_front());
        end else begin
            chk("cmd_idle", DW'({dram_ren, dram_wen}), '0);
        end
        if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            chk("resp_valid", DW'(resp_valid), DW'(r.vld));
            if (r.vld != 2'b00) chk("resp_rdata", resp_rdata, r.data);
        end
        chk("err_orphan", DW'(err_orphan), DW'(exp_orphan));
        r.vld  = 2'b00;
        r.data = '0;
        if (dram_rdata_valid) begin
            if (tag_q.size() == 0) begin
                exp_orphan = 1'b1;
            end else begin
                p = tag_q.pop_front();
                r.vld  = 2'b01 << p;
                r.data = dram_rdata;
            end
        end
        resp_q.push_back(r);
        for (int i = 0; i < 2; i++) begin
            if (exp_ready[i] && (req_ren[i] || req_wen[i])) begin
                c.rd    = !req_wen[i];
                c.addr  = (i == 0) ? a0 : a1;
                c.wdata = (i == 0) ? WD0 : WD1;
                c.wmask = (i == 0) ? WM0 : WM1;
                cmd_q.push_back(c);
                if (c.rd) tag_q.push_back(i);
            end
        end
    endtask

    task automatic step(input logic [1:0] exp_ready, input logic chk_b, input logic [1:0] exp_b);
        @(negedge clock);
        if (chk_b) chk("fixed_ready", DW'(rdy_b), DW'(exp_b));
        monitor(exp_ready);
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        cmd_q.delete();
        tag_q.delete();
        resp_q.delete();
        exp_orphan = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        apply(mk(2'b00, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00));
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_ready", DW'(req_ready), '0);
        chk("rst_resp_valid", DW'(resp_valid), '0);
        chk("rst_resp_rdata", resp_rdata, '0);
        chk("rst_dram_cmd", DW'({dram_ren, dram_wen}), '0);
        chk("rst_dram_addr", DW'(dram_addr), '0);
        chk("rst_dram_wdata", dram_wdata, '0);
        chk("rst_dram_wmask", DW'(dram_wmask), '0);
        chk("rst_err_orphan", DW'(err_orphan), '0);
        resetn = 1'b1;

        //         ren    wen    a0      a1      bsy   cal   rv    rbyte  ready
        vq.push_back(mk(2'b01, 2'b00, 27'h10, 27'h20, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00));
        vq.push_back(mk(2'b01, 2'b00, 27'h10, 27'h20, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00));
        vq.push_back(mk(2'b01, 2'b00, 27'h10, 27'h20, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01));
        vq.push_back(mk(2'b11, 2'b00, 27'h11, 27'h21, 1'b0, 1'b1, 1'b0, 8'h00, 2'b10));
        vq.push_back(mk(2'b11, 2'b00, 27'h12, 27'h22, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01));
        vq.push_back(mk(2'b11, 2'b00, 27'h13, 27'h23, 1'b0, 1'b1, 1'b0, 8'h00, 2'b10));
        vq.push_back(mk(2'b11, 2'b00, 27'h14, 27'h24, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00));
        vq.push_back(mk(2'b01, 2'b10, 27'h14, 27'h25, 1'b0, 1'b1, 1'b0, 8'h00, 2'b10));
        vq.push_back(mk(2'b01, 2'b00, 27'h14, 27'h26, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00));
        vq.push_back(mk(2'b01, 2'b00, 27'h14, 27'h26, 1'b0, 1'b1, 1'b1, 8'h0A, 2'b00));
        vq.push_back(mk(2'b01, 2'b00, 27'h14, 27'h26, 1'b0, 1'b1, 1'b1, 8'h0B, 2'b01));
        vq.push_back(mk(2'b00, 2'b00, 27'h00, 27'h00, 1'b0, 1'b1, 1'b1, 8'h0C, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 27'h00, 27'h00, 1'b0, 1'b1, 1'b1, 8'h0D, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 27'h00, 27'h00, 1'b0, 1'b1, 1'b1, 8'h0E, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 27'h00, 27'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00));
        vq.push_back(mk(2'b01, 2'b01, 27'h40, 27'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01));
        vq.push_back(mk(2'b00, 2'b00, 27'h00, 27'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00));
        vq.push_back(mk(2'b00, 2'b01, 27'h20, 27'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01));
        vq.push_back(mk(2'b00, 2'b10, 27'h00, 27'h30, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00));
        vq.push_back(mk(2'b00, 2'b10, 27'h00, 27'h30, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00));
        vq.push_back(mk(2'b00, 2'b10, 27'h00, 27'h30, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00));
        vq.push_back(mk(2'b00, 2'b10, 27'h00, 27'h30, 1'b0, 1'b1, 1'b0, 8'h00, 2'b10));
        vq.push_back(mk(2'b00, 2'b00, 27'h00, 27'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00));

        foreach (vq[n]) begin
            apply(vq[n]);
            step(vq[n].exp_ready, 1'b0, 2'b00);
        end

        // Both ports write continuously: round-robin alternates, fixed starves port 1.
        for (int n = 0; n < 6; n++) begin
            apply(mk(2'b00, 2'b11, 27'h50 + 27'(n), 27'h60 + 27'(n), 1'b0, 1'b1, 1'b0, 8'h00, 2'b00));
            step((n % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 2'b01);
        end
        apply(mk(2'b00, 2'b00, '0, '0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00));
        step(2'b00, 1'b0, 2'b00);

        // Read data with nothing outstanding: dropped and flagged.
        apply(mk(2'b00, 2'b00, '0, '0, 1'b0, 1'b1, 1'b1, 8'h77, 2'b00));
        step(2'b00, 1'b0, 2'b00);
        apply(mk(2'b00, 2'b00, '0, '0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00));
        repeat (3) step(2'b00, 1'b0, 2'b00);

        // Reset with a read in flight; its late return becomes an orphan.
        apply(mk(2'b01, 2'b00, 27'h70, '0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00));
        step(2'b01, 1'b0, 2'b00);
        apply(mk(2'b00, 2'b00, '0, '0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00));
        step(2'b00, 1'b0, 2'b00);
        resetn = 1'b0;
        #2;
        chk("mid_rst_err_orphan", DW'(err_orphan), '0);
        chk("mid_rst_dram_cmd", DW'({dram_ren, dram_wen}), '0);
        chk("mid_rst_dram_addr", DW'(dram_addr), '0);
        chk("mid_rst_resp_valid", DW'(resp_valid), '0);
        clear_model();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        apply(mk(2'b00, 2'b00, '0, '0, 1'b0, 1'b1, 1'b1, 8'h99, 2'b00));
        step(2'b00, 1'b0, 2'b00);
        apply(mk(2'b00, 2'b00, '0, '0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00));
        repeat (2) step(2'b00, 1'b0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
